// File: rtl/mul_operand_sequencer_pkg.sv
// Shared state encoding and timing constants for the multiplier operand sequencer.
package mul_operand_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        WAIT   = 3'd3,
        CAPT   = 3'd4,
        RESP   = 3'd5
    } state_t;

    // Edges from operand acceptance to out_valid being visible.
    localparam int MUL_SEQ_LAT = 4;

endpackage

// File: rtl/mul_operand_sequencer_if.sv
// Operand, multiplier and result signal bundle; master is the environment side,
// slave is the sequencer.
interface mul_operand_sequencer_if #(
    parameter int N     = 8,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_a;
    logic [N-1:0]     in_b;
    logic [N-1:0]     mul_data;
    logic             mul_load_a;
    logic             mul_load_b;
    logic [2*N-1:0]   mul_product;
    logic             out_valid;
    logic             out_ready;
    logic [2*N-1:0]   out_result;
    logic             busy;
    logic [CNT_W-1:0] ops_done;

    modport master (
        output in_valid, in_a, in_b, mul_product, out_ready,
        input  in_ready, mul_data, mul_load_a, mul_load_b, out_valid, out_result,
               busy, ops_done
    );

    modport slave (
        input  in_valid, in_a, in_b, mul_product, out_ready,
        output in_ready, mul_data, mul_load_a, mul_load_b, out_valid, out_result,
               busy, ops_done
    );
endinterface

// File: rtl/mul_seq_result_reg.sv
// Result holding register: loads d when load_en is high, async clear.
// Latency 1 cycle; no backpressure (holds value while load_en is low).
module mul_seq_result_reg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load_en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q <= '0;
        end else if (load_en) begin
            q <= d;
        end
    end
endmodule

// File: rtl/mul_operand_sequencer.sv
// Serialises operand pairs onto the multiplier bus and returns the captured product.
// Latency: accept edge + 4 edges to out_valid; 6-cycle spacing (5 with MUL_SEQ_OVERLAP_EN).
// Backpressure: out_ready low holds RESP indefinitely; in_ready low while an op is in flight.
import mul_operand_sequencer_pkg::*;

module mul_operand_sequencer #(
    parameter int N     = 8,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   clr,
    mul_operand_sequencer_if.slave bus
);
    state_t           state;
    logic [N-1:0]     op_a;
    logic [N-1:0]     op_b;
    logic             load_a;
    logic             load_b;
    logic             out_valid;
    logic [CNT_W-1:0] ops_done;
    logic             in_ready;
    logic             accept;
    logic             handoff;
    logic [2*N-1:0]   result;

`ifdef MUL_SEQ_OVERLAP_EN
    assign in_ready = (state == IDLE) | ((state == RESP) & bus.out_ready);
`else
    assign in_ready = (state == IDLE);
`endif

    assign accept  = bus.in_valid & in_ready;
    assign handoff = out_valid & bus.out_ready;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= IDLE;
            op_a      <= '0;
            op_b      <= '0;
            load_a    <= 1'b0;
            load_b    <= 1'b0;
            out_valid <= 1'b0;
            ops_done  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a   <= bus.in_a;
                        op_b   <= bus.in_b;
                        load_a <= 1'b1;
                        state  <= LOAD_A;
                    end
                end
                LOAD_A: begin
                    load_a <= 1'b0;
                    load_b <= 1'b1;
                    state  <= LOAD_B;
                end
                LOAD_B: begin
                    load_b <= 1'b0;
                    state  <= WAIT;
                end
                WAIT: state <= CAPT;
                CAPT: begin
                    out_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (handoff) begin
                        out_valid <= 1'b0;
                        if (ops_done != '1) begin
                            ops_done <= ops_done + CNT_W'(1);
                        end
                        // accept is only reachable here in the overlapped build
                        if (accept) begin
                            op_a   <= bus.in_a;
                            op_b   <= bus.in_b;
                            load_a <= 1'b1;
                            state  <= LOAD_A;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    load_a    <= 1'b0;
                    load_b    <= 1'b0;
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    mul_seq_result_reg #(.W(2*N)) u_result (
        .clk     (clk),
        .clr     (clr),
        .load_en (state == CAPT),
        .d       (bus.mul_product),
        .q       (result)
    );

    assign bus.in_ready   = in_ready;
    assign bus.mul_load_a = load_a;
    assign bus.mul_load_b = load_b;
    assign bus.mul_data   = load_a ? op_a : (load_b ? op_b : '0);
    assign bus.out_valid  = out_valid;
    assign bus.out_result = result;
    assign bus.busy       = (state != IDLE);
    assign bus.ops_done   = ops_done;
endmodule
